// File: rtl/bitty_defs.sv
// Shared definitions for the bitty core blocks: instruction width, fetch
// sequencer state encoding and the default watchdog limit.
package bitty_defs;

    localparam int INSTR_W     = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_NEXT      = 3'd5
    } fetch_state_t;

    // Counter width able to hold the value `limit` itself.
    function automatic int wd_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT.
module bitty_watchdog
    import bitty_defs::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = wd_width(TIMEOUT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_next;

    // A clear in the same cycle as an enable restarts the count at 1, so the
    // clearing cycle itself is the first counted cycle.
    assign w_base  = clear ? '0 : r_count;
    assign w_next  = w_base + CNT_W'(count_en);
    assign expired = count_en && (w_next == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction fetch sequencer: walks pc over prog_len instructions, hands each
// word to the core with a one-cycle run pulse and waits for done under a watchdog.
module bitty_fetch
    import bitty_defs::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  prog_len,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               run,
    output logic [INSTR_W-1:0] instruction,
    input  logic               done,
    output logic               busy,
    output logic               finished,
    output logic               timeout_err,
    output logic [ADDR_W-1:0]  inst_count
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_count;
    logic [INSTR_W-1:0] r_instr;
    logic               r_finished;
    logic               r_timeout_err;

    logic w_run;
    logic w_busy;
    logic w_wd_clear;
    logic w_wd_count;
    logic w_wd_expired;
    logic w_last;

    // Watchdog restarts on issue and runs only while the core has not answered,
    // so a done in the expiry cycle suppresses the expiry.
    assign w_wd_clear = (r_state == S_ISSUE);
    assign w_wd_count = (r_state == S_ISSUE) || ((r_state == S_WAIT_DONE) && !done);
    assign w_last     = (r_count == r_len);

    bitty_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_wd_clear),
        .count_en (w_wd_count),
        .expired  (w_wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_run        = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start && (prog_len != '0)) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_LATCH;
            end
            S_LATCH: begin
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                w_run        = 1'b1;
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    w_next_state = S_NEXT;
                end else if (w_wd_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_NEXT: begin
                w_next_state = w_last ? S_IDLE : S_FETCH;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_instr       <= '0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            r_finished <= 1'b1;
                        end else begin
                            r_len         <= prog_len;
                            r_pc          <= '0;
                            r_count       <= '0;
                            r_timeout_err <= 1'b0;
                        end
                    end
                end
                S_LATCH: begin
                    r_instr <= mem_rdata;
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_count <= r_count + ADDR_W'(1);
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                S_NEXT: begin
                    // pc is ADDR_W wide, so the increment wraps all-ones to zero.
                    if (w_last) begin
                        r_finished <= 1'b1;
                    end else begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr    = r_pc;
    assign run         = w_run;
    assign busy        = w_busy;
    assign instruction = r_instr;
    assign finished    = r_finished;
    assign timeout_err = r_timeout_err;
    assign inst_count  = r_count;

endmodule

// File: tb/tb_bitty_fetch.sv
// Randomized bench for bitty_fetch: a memory model and a program-level
// expectation of fetch order, counts, finish and watchdog behaviour.
module tb_bitty_fetch;

    localparam int AW = 4;
    localparam int TO = 8;
    localparam int MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] prog_len;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          run;
    logic [15:0]   instruction;
    logic          done;
    logic          busy;
    logic          finished;
    logic          timeout_err;
    logic [AW-1:0] inst_count;

    logic [15:0] tb_mem [MEM_N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= tb_mem[mem_addr];

    bitty_fetch #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_len    (prog_len),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .run         (run),
        .instruction (instruction),
        .done        (done),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .inst_count  (inst_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < MEM_N; i++) tb_mem[i] = 16'($urandom);
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        start    = 1'b1;
        prog_len = AW'(len);
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Leaves the caller at the negedge where run is high.
    task automatic wait_run(output bit got);
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            if (run) got = 1'b1;
            else @(negedge clk);
        end
        check("run_seen", got, 1);
    endtask

    // lat = 0 picks a random core latency per instruction.
    task automatic run_prog(input int len, input int lat_fix, input bit spurious, input bit force_wrap);
        int          exp_pc;
        int          lat;
        bit          got;
        logic [15:0] exp_instr;
        exp_pc = 0;
        pulse_start(len);
        check("busy_on", busy, 1);
        check("err_clr", timeout_err, 0);
        check("cnt_clr", inst_count, 0);
        for (int k = 0; k < len; k++) begin
            wait_run(got);
            if (!got) return;
            exp_instr = tb_mem[exp_pc];
            check("instr", instruction, exp_instr);
            check("addr", mem_addr, exp_pc);
            if (spurious && k == 1) done = 1'b1;
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, TO - 1));
            for (int j = 1; j <= lat; j++) begin
                @(negedge clk);
                check("run_pulse", run, 0);
                check("instr_hold", instruction, exp_instr);
                check("cnt_wait", inst_count, k);
                if (force_wrap && k == 0 && j == 1) force dut.r_pc = 4'hF;
                if (force_wrap && k == 0 && j == 2) begin
                    release dut.r_pc;
                    check("forced_pc", mem_addr, 15);
                    exp_pc = 15;
                end
                done = (j == lat);
            end
            @(negedge clk);
            done = 1'b0;
            check("cnt_inc", inst_count, k + 1);
            check("fin_early", finished, 0);
            if (k < len - 1) begin
                exp_pc = (exp_pc + 1) % MEM_N;
                if (spurious && k == 0) begin
                    @(negedge clk);
                    check("fetch_addr", mem_addr, exp_pc);
                    done     = 1'b1;
                    start    = 1'b1;
                    prog_len = ~AW'(len);
                    @(negedge clk);
                    done  = 1'b0;
                    start = 1'b0;
                    check("spur_cnt", inst_count, k + 1);
                    check("spur_addr", mem_addr, exp_pc);
                end
            end
        end
        @(negedge clk);
        check("finished", finished, 1);
        check("busy_off", busy, 0);
        check("cnt_final", inst_count, len);
        check("no_err", timeout_err, 0);
        @(negedge clk);
        check("fin_pulse", finished, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_instr"}, instruction, 0);
        check({tag, "_run"}, run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fin"}, finished, 0);
        check({tag, "_err"}, timeout_err, 0);
        check({tag, "_cnt"}, inst_count, 0);
    endtask

    initial begin
        bit got;
        reset    = 1'b1;
        start    = 1'b0;
        done     = 1'b0;
        prog_len = '0;
        randomize_mem();
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_run", run, 0);
        end

        // Normal program
        tb_mem[0] = 16'h1001;
        tb_mem[1] = 16'h2002;
        tb_mem[2] = 16'h3003;
        run_prog(3, 2, 1'b0, 1'b0);

        // Zero-length program
        pulse_start(0);
        check("zero_fin", finished, 1);
        check("zero_busy", busy, 0);
        check("zero_run", run, 0);
        @(negedge clk);
        check("zero_fin_off", finished, 0);
        check("zero_busy2", busy, 0);

        // Watchdog expiry with no done
        pulse_start(2);
        wait_run(got);
        for (int j = 1; j <= TO; j++) begin
            @(negedge clk);
            if (j < TO) begin
                check("wd_early", timeout_err, 0);
                check("wd_busy", busy, 1);
            end else begin
                check("wd_err", timeout_err, 1);
                check("wd_busy_off", busy, 0);
                check("wd_cnt", inst_count, 0);
            end
            check("wd_nofin", finished, 0);
        end
        repeat (4) begin
            @(negedge clk);
            check("wd_norun", run, 0);
            check("wd_sticky", timeout_err, 1);
            check("wd_nofin2", finished, 0);
        end

        // Spurious done/start, done during ISSUE, then done on the last allowed cycle
        randomize_mem();
        run_prog(4, 0, 1'b1, 1'b0);
        run_prog(2, TO - 1, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            randomize_mem();
            run_prog(int'($urandom_range(1, MEM_N - 1)), 0, 1'b0, 1'b0);
        end

        // Wrap-around
        run_prog(MEM_N - 1, 1, 1'b0, 1'b0);
        run_prog(2, 3, 1'b0, 1'b1);

        // Reset in WAIT_DONE of the second instruction
        randomize_mem();
        pulse_start(3);
        wait_run(got);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_run(got);
        @(negedge clk);
        check("pre_rst_addr", mem_addr, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        done  = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_run", run, 0);
            check("post_rst_cnt", inst_count, 0);
            check("post_rst_busy", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bitty_fetch.md
BITTY_FETCH -- requirements
Module: bitty_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction memory address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles allowed between run and done.
REQ-003 Port clk, input, 1: the single clock; one clock; reset is asynchronous and active-high.
REQ-004 Port reset, input, 1: the asynchronous, active-high reset.
REQ-005 Port start, input, 1: a one-cycle pulse that begins program execution.
REQ-006 Port prog_len, input, ADDR_W: the number of instructions to issue, sampled on start.
REQ-007 Port mem_addr, output, ADDR_W: the instruction memory read address.
REQ-008 Port mem_rdata, input, 16: the instruction memory read data, valid one cycle after mem_addr.
REQ-009 Port run, output, 1: a one-cycle pulse to the core requesting execution of the instruction.
REQ-010 Port instruction, output, 16: the instruction word presented to the core.
REQ-011 Port done, input, 1: the pulse from the core marking instruction completion.
REQ-012 Port busy, output, 1: high from start acceptance until return to IDLE.
REQ-013 Port finished, output, 1: a one-cycle pulse when the program completes normally.
REQ-014 Port timeout_err, output, 1: sticky error flag, set on watchdog expiry and cleared by the next accepted start.
REQ-015 Port inst_count, output, ADDR_W: the number of instructions completed in the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, and NEXT.
REQ-017 IDLE: start with prog_len != 0 SHALL go to FETCH, clear pc, inst_count and timeout_err, and set busy.
REQ-018 IDLE: start with prog_len == 0 SHALL pulse finished the next cycle and SHALL NOT raise busy or run.
REQ-019 FETCH: mem_addr = pc for one cycle; then go to LATCH.
REQ-020 LATCH: capture mem_rdata into the instruction register; then go to ISSUE.
REQ-021 ISSUE: run = 1 for exactly one cycle; clear the watchdog; then go to WAIT_DONE.
REQ-022 The instruction output SHALL stay stable from ISSUE until the matching done is seen.
REQ-023 WAIT_DONE: done = 1 SHALL increment inst_count and go to NEXT.
REQ-024 WAIT_DONE: the watchdog SHALL count up by 1 per cycle while done = 0.
REQ-025 WAIT_DONE: if the watchdog reaches TIMEOUT, set timeout_err, drop busy, and return to IDLE without pulsing finished.
REQ-026 NEXT: if inst_count == prog_len, pulse finished, drop busy, and go to IDLE.
REQ-027 NEXT: otherwise increment pc and go to FETCH.
REQ-028 pc SHALL increment modulo 2^ADDR_W, so it wraps from all-ones to 0.
REQ-029 done asserted in any state other than WAIT_DONE SHALL be ignored.
REQ-030 done coincident with ISSUE SHALL be ignored; only done in WAIT_DONE counts.
REQ-031 start while busy = 1 SHALL be ignored, and prog_len SHALL NOT be resampled.
REQ-032 If done and watchdog expiry occur in the same cycle, done wins and no error is set.
REQ-033 Steady-state issue interval SHALL be 4 cycles plus the core latency (FETCH, LATCH, ISSUE, NEXT).

Reset
REQ-034 reset SHALL force IDLE asynchronously, at any time including mid-instruction.
REQ-035 On reset, the following SHALL all be 0: pc, mem_addr, instruction, run, busy, finished, timeout_err, inst_count, and the watchdog.
REQ-036 After reset release, no run SHALL be issued until a new start is accepted.

Structure
REQ-037 The state encodings, the 16-bit instruction width, and the TIMEOUT default SHALL live in the shared bitty_defs definitions file used by the bitty core blocks.
REQ-038 The watchdog SHALL be one sub-module, bitty_watchdog, with inputs clear and count_en, an output expired, and parameter TIMEOUT.
REQ-039 The remaining logic SHALL stay flat in bitty_fetch.

Verification
REQ-040 Scenario, normal program: memory 0..2 = 16'h1001, 16'h2002, 16'h3003, prog_len = 3, and the core returns done 2 cycles after each run -> three run pulses with instruction 1001, 2002 and 3003 in order, inst_count = 3, and one finished pulse.
REQ-041 Scenario, zero length: start with prog_len = 0 -> finished one cycle later, with no run and busy = 0 throughout.
REQ-042 Scenario, watchdog: TIMEOUT = 8 and done is never asserted -> timeout_err = 1 exactly 8 cycles after run, busy = 0, no finished pulse, and inst_count = 0.
REQ-043 Scenario, spurious inputs: done pulsed during FETCH and start pulsed mid-program -> no change to inst_count, pc, or prog_len, and the program completes normally.
REQ-044 Scenario, wrap-around: ADDR_W = 4, start with pc stepping past 15 using prog_len = 15 after a prior run -> mem_addr sequence 0..14, and a forced wrap check in which pc goes 15 -> 0.
REQ-045 Scenario, reset mid-run: reset asserted in WAIT_DONE -> all outputs 0 in the same cycle, and a later done causes no effect.
